// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_addsub
//  Purpose  : Digit-serial adder/subtractor, f = a + (sub ? ~b : b) + c0,
//             CHUNK bits per clock behind a start/busy/done handshake.
//             Optional signed-overflow output enabled by ADDSUB_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
module serial_addsub #(
   parameter int WIDTH = 4,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c0,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] f,
   output logic             c4
`ifdef ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int c_NCHUNK = WIDTH / CHUNK;
   localparam int c_CW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [c_CW-1:0]  r_cnt;
   logic             r_carry;

   logic [CHUNK:0]   w_sum;
   logic [WIDTH-1:0] w_res_next;

   // Operands shift right one chunk per cycle, so the active chunk is always
   // the low CHUNK bits; result chunks enter at the top and drift down.
   assign w_sum      = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, r_carry};
   assign w_res_next = (r_res >> CHUNK) | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

`ifdef ADDSUB_OVF_EN
   logic w_ovf;
   // Carry into the MSB equals a^b^sum at that bit; XOR with carry out.
   assign w_ovf = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1] ^ w_sum[CHUNK];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         f       <= '0;
         c4      <= 1'b0;
`ifdef ADDSUB_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= c0;
                  r_cnt   <= '0;
                  r_res   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_carry <= w_sum[CHUNK];
               r_res   <= w_res_next;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  f       <= w_res_next;
                  c4      <= w_sum[CHUNK];
`ifdef ADDSUB_OVF_EN
                  ovf     <= w_ovf;
`endif
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/serial_addsub.md
# serial_addsub

Parametrised digit-serial adder/subtractor for the arithmetic labs. It computes f = a + b + c0, or f = a + ~b + c0 in subtract mode, over WIDTH bits. It processes CHUNK bits per clock behind a start/busy/done handshake. It is the registered, multi-cycle successor to the 4-bit combinational adder and reproduces that adder's results when WIDTH=4.

## Interface
- WIDTH, default 4: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, default 1: bits added per cycle; NCHUNK = WIDTH/CHUNK.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled at each rising edge.
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- c0  in  1  carry-in, captured on accepted start.
- sub  in  1  mode, captured on accepted start: 0 = add, 1 = add ~b (c0=1 gives a−b).
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when f and c4 become valid.
- f  out  WIDTH  result.
- c4  out  1  carry-out of the MSB.
- ovf  out  1  signed overflow; present only under ADDSUB_OVF_EN.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE with start=1: capture a, b, c0 and sub; clear the chunk counter, the partial result and the running carry (the running carry is loaded with c0); go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - Add the operand chunk at index = counter (LSB chunk first).
  - The B chunk is inverted when sub=1.
  - Chunk sum = a_chunk + b_chunk' + carry, computed CHUNK+1 bits wide.
  - Write the low CHUNK bits into the result slice; register the top bit as the new carry.
  - Increment the counter.
- RUN after the last chunk (counter = NCHUNK−1): load f with the assembled result and c4 with the final carry; go to DONE.
- start is ignored in RUN; captured operands do not change.
- DONE with start=1: accept the new request exactly as in IDLE and go to RUN. Back-to-back issue is therefore allowed.
- DONE with start=0: go to IDLE.
- f, c4 and ovf change only on the RUN→DONE transition. They hold their value through IDLE and through any later RUN until the next DONE.
- Arithmetic is modulo 2^WIDTH. c4 is the true carry of the full WIDTH-bit operation, including in subtract mode (c4=1 means no borrow).
- Reset (asynchronous, any state, including mid-RUN):
  - State = IDLE.
  - busy=0, done=0, f=0, c4=0, ovf=0.
  - Counter, captured operands and running carry = 0.
  - The in-flight operation is discarded, and no done is produced for it.

## Timing
- Latency: start sampled at edge E. busy is high for the NCHUNK cycles after E. done is high for the single cycle after edge E+NCHUNK, with f and c4 valid in that cycle.
- Throughput: one result per NCHUNK+1 cycles when start is held high or re-asserted during DONE.
- CHUNK=WIDTH: a single RUN cycle, with done one cycle after RUN.
- rst_n deassertion is synchronised by the user. The first start is accepted at the first edge with rst_n=1.

## Configuration
- ADDSUB_OVF_EN defined:
  - The ovf port exists.
  - On RUN→DONE, ovf = carry into the MSB XOR carry out of the MSB (signed two's-complement overflow of a + b' + c0).
  - ovf holds its value with f.
- ADDSUB_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=4, CHUNK=1:
  - a=0, b=1, c0=1, sub=0 → done 4 cycles after start; f=4'b0010, c4=0.
  - a=1, b=1, c0=1 → f=4'b0011, c4=0.
  - a=15, b=1, c0=1 → f=4'b0001, c4=1.
- WIDTH=4, CHUNK=1, subtract:
  - a=5, b=7, sub=1, c0=1 → f=4'b1110, c4=0 (borrow).
  - a=7, b=5 → f=4'b0010, c4=1.
- WIDTH=8, CHUNK=4:
  - a=8'hF0, b=8'h10, c0=0 → done 2 cycles after start; f=8'h00, c4=1.
  - start held high → done every 3rd cycle.
  - start pulsed again during busy → no effect on the in-flight result.
- Reset mid-operation: WIDTH=4, CHUNK=1; drop rst_n 2 cycles after start.
  - busy, done, f and c4 go to 0 immediately.
  - No done pulse follows.
  - The next start completes normally.
- ADDSUB_OVF_EN, WIDTH=4:
  - a=7, b=1, c0=0 → f=4'b1000, ovf=1.
  - a=3, b=1 → ovf=0.
  - a=8, b=8 (0x8+0x8) → f=0, c4=1, ovf=1.
